// File: rtl/piso_frame_serializer.sv
// Parallel-in serial-out frame transmitter feeding an N-bit bidirectional SIPO.
// Optional even-parity output enabled by defining SERIALIZER_PARITY_EN.
module piso_frame_serializer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] data_in,
    input  logic         data_valid,
    output logic         data_ready,
    input  logic         msb_first,
    output logic         serial_out,
    output logic         shift_en,
    output logic         dir_out,
    output logic         frame_done,
    output logic         busy
`ifdef SERIALIZER_PARITY_EN
    ,
    output logic         parity_out
`endif
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          dir_q,   dir_d;
    logic          handshake;

    // data_ready is gated with reset_n, so no word is accepted while reset is held.
    assign handshake = data_valid && data_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    shreg_d = data_in;
                    dir_d   = msb_first;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // The outgoing bit leaves at the end toward which the word shifts.
                if (dir_q) begin
                    shreg_d = {shreg_q[N-2:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[N-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        data_ready = 1'b0;
        shift_en   = 1'b0;
        serial_out = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b0;
        dir_out    = dir_q;
        case (state_q)
            IDLE: begin
                data_ready = reset_n;
            end
            SHIFT: begin
                shift_en   = 1'b1;
                busy       = 1'b1;
                serial_out = dir_q ? shreg_q[N-1] : shreg_q[0];
            end
            DONE: begin
                frame_done = 1'b1;
                busy       = 1'b1;
            end
            default: begin
                data_ready = 1'b0;
            end
        endcase
    end

`ifdef SERIALIZER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else if (state_q == IDLE && handshake) begin
            parity_q <= ^data_in;
        end
    end

    assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_piso_frame_serializer.sv
// [TB] Self-checking bench for piso_frame_serializer: directed frames plus
// randomized traffic against a timeline model of each frame and an attached SIPO model.
module tb_piso_frame_serializer;

   localparam int N = 8;

   logic         clk;
   logic         reset_n;
   logic [N-1:0] data_in;
   logic         data_valid;
   logic         data_ready;
   logic         msb_first;
   logic         serial_out;
   logic         shift_en;
   logic         dir_out;
   logic         frame_done;
   logic         busy;
`ifdef SERIALIZER_PARITY_EN
   logic         parity_out;
`endif

   piso_frame_serializer #(.N(N)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .msb_first  (msb_first),
      .serial_out (serial_out),
      .shift_en   (shift_en),
      .dir_out    (dir_out),
      .frame_done (frame_done),
      .busy       (busy)
`ifdef SERIALIZER_PARITY_EN
      ,
      .parity_out (parity_out)
`endif
   );

   // 10 ns clock; inputs change 2 ns after rising edges, outputs sampled on falling edges.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passCount  = 0;
   int checkCount = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Frame timeline model: mPos is the cycle index within the current frame
   // (0 = idle, 1..N = bit cycles, N+1 = done cycle).
   int           mPos;
   logic [N-1:0] mWord;
   logic         mDir;
   logic         mPar;
   int           cycleCount = 0;
   int           hsQ[$];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mPos = 0;
         mDir = 1'b0;
         mPar = 1'b0;
      end else begin
         cycleCount++;
         if (mPos == 0) begin
            if (data_valid) begin
               mPos  = 1;
               mWord = data_in;
               mDir  = msb_first;
               mPar  = ^data_in;
               hsQ.push_back(cycleCount);
            end
         end else if (mPos == N + 1) begin
            mPos = 0;
         end else begin
            mPos++;
         end
      end
   end

   // Behavioural downstream SIPO: left_right=1 inserts at LSB, otherwise at MSB.
   logic [N-1:0] sipo;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sipo <= '0;
      end else if (shift_en) begin
         sipo <= dir_out ? {sipo[N-2:0], serial_out} : {serial_out, sipo[N-1:1]};
      end
   end

   // Per-cycle comparison of every output against the model.
   logic [N-1:0] sentBits;
   logic [N-1:0] lastSipo;
   int           shiftCount = 0;
   int           doneCount  = 0;
   int           doneCycle  = 0;

   always @(negedge clk) begin
      logic eReady, eShift, eSerial, eDone, eBusy, eDir;
      eReady = 1'b0; eShift = 1'b0; eSerial = 1'b0; eDone = 1'b0; eBusy = 1'b0;
      eDir   = reset_n ? mDir : 1'b0;
      if (reset_n) begin
         if (mPos == 0) begin
            eReady = 1'b1;
         end else if (mPos <= N) begin
            eShift  = 1'b1;
            eBusy   = 1'b1;
            eSerial = mDir ? mWord[N-mPos] : mWord[mPos-1];
         end else begin
            eDone = 1'b1;
            eBusy = 1'b1;
         end
      end
      checkOutput("data_ready", data_ready, eReady);
      checkOutput("shift_en",   shift_en,   eShift);
      checkOutput("serial_out", serial_out, eSerial);
      checkOutput("frame_done", frame_done, eDone);
      checkOutput("busy",       busy,       eBusy);
      checkOutput("dir_out",    dir_out,    eDir);
`ifdef SERIALIZER_PARITY_EN
      checkOutput("parity_out", parity_out, reset_n ? mPar : 1'b0);
`endif
      if (shift_en) begin
         sentBits = {sentBits[N-2:0], serial_out};
         shiftCount++;
      end
      if (reset_n && frame_done) begin
         checkOutput("sipo_word", sipo, mWord);
         lastSipo  = sipo;
         doneCycle = cycleCount + 1;
         doneCount++;
      end
   end

   // Offers one word and returns 2 ns after the accepting edge.
   task automatic applyStimulus(input logic [N-1:0] word, input logic msb, input logic holdValid);
      logic rdy;
      bit   taken;
      taken      = 1'b0;
      data_in    = word;
      msb_first  = msb;
      data_valid = 1'b1;
      for (int i = 0; i < 40 && !taken; i++) begin
         rdy = data_ready;
         @(posedge clk);
         taken = rdy && reset_n;
      end
      if (!taken) checkOutput("handshake_timeout", 0, 1);
      #2;
      if (!holdValid) data_valid = 1'b0;
      data_in   = N'($urandom);
      msb_first = 1'($urandom);
   endtask

   task automatic waitIdle();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = data_ready;
      end
      if (!seen) checkOutput("idle_timeout", 0, 1);
      @(posedge clk);
      #2;
   endtask

   task automatic pulseReset(input int cycles);
      reset_n = 1'b0;
      repeat (cycles) @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      int t0;
      int d0;
      reset_n    = 1'b0;
      data_in    = '0;
      data_valid = 1'b0;
      msb_first  = 1'b0;
      sentBits   = '0;
      repeat (3) @(posedge clk);
      #2;

      // Reset state with data_valid asserted must not advertise readiness.
      data_valid = 1'b1;
      #1;
      checkOutput("rst_data_ready", data_ready, 0);
      checkOutput("rst_busy",       busy,       0);
      checkOutput("rst_dir_out",    dir_out,    0);
      data_valid = 1'b0;
      reset_n    = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_ready", data_ready, 1);
      @(posedge clk);
      #2;

      // A5 MSB first.
      shiftCount = 0;
      applyStimulus(8'hA5, 1'b1, 1'b0);
      t0 = hsQ[$];
      @(negedge clk);
`ifdef SERIALIZER_PARITY_EN
      checkOutput("parity_a5", parity_out, 0);
`endif
      checkOutput("dir_a5", dir_out, 1);
      waitIdle();
      checkOutput("bits_a5",    sentBits,      8'hA5);
      checkOutput("sipo_a5",    lastSipo,      8'hA5);
      checkOutput("shifts_a5",  shiftCount,    8);
      checkOutput("done_lat_a5", doneCycle - t0, 9);

      // 3C LSB first; sequence 0,0,1,1,1,1,0,0.
      shiftCount = 0;
      applyStimulus(8'h3C, 1'b0, 1'b0);
      waitIdle();
      checkOutput("bits_3c",   sentBits,   8'h3C);
      checkOutput("sipo_3c",   lastSipo,   8'h3C);
      checkOutput("dir_3c",    dir_out,    0);
      checkOutput("shifts_3c", shiftCount, 8);

      // Back-to-back with valid held and data_in disturbed mid-frame.
      applyStimulus(8'h11, 1'b1, 1'b1);
      t0 = hsQ[$];
      data_in = 8'hFF;
      repeat (4) @(posedge clk);
      #2;
      data_in = 8'h22;
      applyStimulus(8'h22, 1'b1, 1'b0);
      checkOutput("hs_spacing", hsQ[$] - t0, 10);
      checkOutput("sipo_11", lastSipo, 8'h11);
      waitIdle();
      checkOutput("sipo_22", lastSipo, 8'h22);

`ifdef SERIALIZER_PARITY_EN
      applyStimulus(8'h07, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("parity_07", parity_out, 1);
      waitIdle();
      checkOutput("parity_07_hold", parity_out, 1);
`endif

      // Reset after three bits of C3.
      d0 = doneCount;
      applyStimulus(8'hC3, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("abort_shift_en", shift_en, 0);
      checkOutput("abort_busy",     busy,     0);
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      checkOutput("abort_no_done", doneCount, d0);
      applyStimulus(8'h5A, 1'b0, 1'b0);
      waitIdle();
      checkOutput("sipo_5a",     lastSipo,  8'h5A);
      checkOutput("done_after_abort", doneCount, d0 + 1);

      // Randomized traffic with occasional mid-frame resets.
      for (int f = 0; f < 40; f++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #2;
         applyStimulus(N'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(0, N)) @(posedge clk);
            #2;
            pulseReset($urandom_range(1, 3));
         end else begin
            waitIdle();
         end
      end
      data_valid = 1'b0;
      waitIdle();

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/piso_frame_serializer.md
Name: piso_frame_serializer

Overview:
- Parallel-in serial-out transmitter; sits directly upstream of the team's N-bit bidirectional SIPO shift register.
- Accepts an N-bit word on a valid/ready handshake.
- Drives the SIPO's serial data, shift-enable and direction inputs, so that after one frame the SIPO holds exactly the accepted word.
- Pulses frame_done when the last bit has been shifted.

Parameters:
- N, 8, word width in bits; legal range N >= 2; must equal the downstream SIPO width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- data_in  input  N  parallel word to transmit; sampled only on handshake.
- data_valid  input  1  upstream asserts when data_in is valid.
- data_ready  output  1  high when block can accept a word (IDLE).
- msb_first  input  1  bit order for the word; sampled only on handshake (1 = MSB first).
- serial_out  output  1  serial bit; connects to SIPO serial_in.
- shift_en  output  1  one-cycle-per-bit strobe; connects to SIPO load.
- dir_out  output  1  shift direction; connects to SIPO left_right (1 = shift toward MSB).
- frame_done  output  1  single-cycle pulse after the last bit.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- States: IDLE, SHIFT, DONE. Registers:
  - state
  - shreg[N-1:0]
  - bit counter cnt, width $clog2(N)
  - dir_q
- Reset (reset_n low, asynchronous):
  - state = IDLE; shreg = 0; cnt = 0; dir_q = 0.
  - All outputs 0 while reset_n is low, including data_ready (data_ready is gated with reset_n).
- IDLE:
  - data_ready = 1; shift_en = 0; serial_out = 0; busy = 0.
  - Handshake = data_valid && data_ready at a rising edge. On handshake:
    - shreg <= data_in
    - dir_q <= msb_first
    - cnt <= 0
    - state <= SHIFT
  - data_valid low: stay in IDLE.
- SHIFT:
  - shift_en = 1; busy = 1; data_ready = 0.
  - serial_out = shreg[N-1] if dir_q = 1, else shreg[0].
  - Each cycle:
    - dir_q = 1: shreg shifts left (toward MSB).
    - dir_q = 0: shreg shifts right (toward LSB).
    - cnt increments.
  - When cnt == N-1: state <= DONE.
  - Exactly N consecutive shift_en cycles per frame.
- DONE:
  - frame_done = 1 for exactly one cycle; shift_en = 0; busy = 1; data_ready = 0.
  - Unconditional return to IDLE.
- dir_out = dir_q in every state; holds the last frame's direction while IDLE.
- Timing: handshake at edge t → bits on cycles t+1 … t+N → frame_done on cycle t+N+1 → data_ready high on cycle t+N+2. Minimum word spacing N+2 cycles.
- Ordering contract: with dir_out = 1 (SIPO inserts at LSB), MSB is sent first; with dir_out = 0 (SIPO inserts at MSB), LSB is sent first. Either way the SIPO holds data_in after the frame.
- data_valid, data_in and msb_first changes during SHIFT/DONE are ignored; no word is lost, because data_ready is low.
- Reset mid-frame: shift_en and busy drop asynchronously; frame is aborted, no frame_done; next frame starts clean. Downstream partial contents are undefined; system resets both blocks together.
- No combinational path from data_valid to any output except through the registered state.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- When defined:
  - Adds output port parity_out (1 bit) = XOR of all bits of the word captured at handshake (even parity); it is a register updated only on handshake.
  - Reset value 0.
  - Stable from cycle t+1 until the next handshake.
- When undefined: parity_out port and its logic are absent. All other behaviour is identical.

Test Plan (N=8):
1. Reset: hold reset_n = 0 mid-sim → data_ready, shift_en, serial_out, frame_done, busy, dir_out all 0. Release → data_ready = 1 from first edge in IDLE.
2. data_in = 8'hA5, msb_first = 1, handshake at t → serial_out = 1,0,1,0,0,1,0,1 on t+1..t+8; shift_en high exactly 8 cycles; dir_out = 1; frame_done at t+9; attached SIPO reads 8'hA5.
3. data_in = 8'h3C, msb_first = 0 → serial_out = 0,0,1,1,1,1,0,0; dir_out = 0; SIPO reads 8'h3C.
4. data_valid held high with 8'h11 then 8'h22, data_in changed to 8'hFF mid-frame → first frame sends 8'h11 unaffected; second handshake at t+10; SIPO reads 8'h11 then 8'h22.
5. Pull reset_n low after 3 bits of 8'hC3 → shift_en drops immediately, no frame_done. After release, a frame of 8'h5A completes correctly.
6. SERIALIZER_PARITY_EN defined: 8'hA5 → parity_out = 0; 8'h07 → parity_out = 1, valid from t+1.
